// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter.
// Optional build macro: ALU_ARB_LOCK_EN (requester lock input).
package alu_arb_pkg;

  localparam int NREQ_DEF = 4;
  localparam int IDW_DEF  = 2;
  localparam int FNW      = 4;
  localparam int OSW      = 2;
  localparam int DW       = 8;

  // OSEL: 00 add, 01 shift, 1x logic
  localparam logic [OSW-1:0] OSEL_ADD   = 2'b00;
  localparam logic [OSW-1:0] OSEL_SHIFT = 2'b01;
  localparam logic [OSW-1:0] OSEL_LOGIC = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin picker: first request at or
// above the pointer, wrapping modulo NREQ.
module rr_pick
  import alu_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = IDW_DEF
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  logic [2*NREQ-1:0] dbl;
  logic [IDW-1:0]    off;
  logic [IDW:0]      sum;
  logic              found;

  // Rotate so the pointer is bit 0, take lowest set bit, rotate back
  always_comb begin
    dbl   = {req_i, req_i} >> ptr_i;
    off   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && dbl[k]) begin
        found = 1'b1;
        off   = IDW'(k);
      end
    end
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= (IDW+1)'(NREQ)) begin
      idx_o = IDW'(sum - (IDW+1)'(NREQ));
    end else begin
      idx_o = sum[IDW-1:0];
    end
    if (!found) begin
      idx_o = '0;
    end
    gnt_o = found ? (NREQ'(1) << idx_o) : '0;
    any_o = found;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational 8-bit ALU.
// Optional build macro: ALU_ARB_LOCK_EN (adds REQ_LOCK).
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = IDW_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NREQ-1:0]   REQ_VALID,
`ifdef ALU_ARB_LOCK_EN
  input  logic [NREQ-1:0]   REQ_LOCK,
`endif
  output logic [NREQ-1:0]   REQ_READY,
  input  logic [OSW*NREQ-1:0] REQ_OSEL,
  input  logic [FNW*NREQ-1:0] REQ_FN,
  input  logic [DW*NREQ-1:0]  REQ_A,
  input  logic [DW*NREQ-1:0]  REQ_B,
  output logic [OSW-1:0]    ALU_OSEL,
  output logic [FNW-1:0]    ALU_FN,
  output logic [DW-1:0]     ALU_A,
  output logic [DW-1:0]     ALU_B,
  input  logic [DW-1:0]     ALU_Y,
  input  logic              ALU_C,
  input  logic              ALU_V,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [IDW-1:0]    RSP_ID,
  output logic [DW-1:0]     RSP_Y,
  output logic              RSP_C,
  output logic              RSP_V,
  output logic              RSP_Z
);

  state_t state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;

  logic [OSW-1:0] alu_osel_q, alu_osel_d;
  logic [FNW-1:0] alu_fn_q, alu_fn_d;
  logic [DW-1:0]  alu_a_q, alu_a_d;
  logic [DW-1:0]  alu_b_q, alu_b_d;

  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [DW-1:0]  rsp_y_q, rsp_y_d;
  logic           rsp_c_q, rsp_c_d;
  logic           rsp_v_q, rsp_v_d;
  logic           rsp_z_q, rsp_z_d;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  win_idx;
  logic            win_any;
  logic            win_hold;
  logic [IDW-1:0]  ptr_adv;

  logic [OSW-1:0] win_osel;
  logic [FNW-1:0] win_fn;
  logic [DW-1:0]  win_a;
  logic [DW-1:0]  win_b;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req_i (REQ_VALID),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  // Accept strobe only while idle and out of reset
  assign REQ_READY =
    (state_q == IDLE && RST_N) ? gnt : '0;

  // Select the winner's operand slices
  always_comb begin
    win_osel = '0;
    win_fn   = '0;
    win_a    = '0;
    win_b    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        win_osel = REQ_OSEL[OSW*i +: OSW];
        win_fn   = REQ_FN[FNW*i +: FNW];
        win_a    = REQ_A[DW*i +: DW];
        win_b    = REQ_B[DW*i +: DW];
      end
    end
  end

  // Pointer update: a locked winner keeps top priority
  always_comb begin
`ifdef ALU_ARB_LOCK_EN
    win_hold = |(REQ_LOCK & gnt);
`else
    win_hold = 1'b0;
`endif
    if (win_idx == IDW'(NREQ - 1)) begin
      ptr_adv = '0;
    end else begin
      ptr_adv = win_idx + IDW'(1);
    end
  end

  // Next-state and register-input logic
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    alu_osel_d  = alu_osel_q;
    alu_fn_d    = alu_fn_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_y_d     = rsp_y_q;
    rsp_c_d     = rsp_c_q;
    rsp_v_d     = rsp_v_q;
    rsp_z_d     = rsp_z_q;
    unique case (state_q)
      IDLE: begin
        if (win_any) begin
          alu_osel_d = win_osel;
          alu_fn_d   = win_fn;
          alu_a_d    = win_a;
          alu_b_d    = win_b;
          rsp_id_d   = win_idx;
          ptr_d      = win_hold ? win_idx : ptr_adv;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        rsp_y_d     = ALU_Y;
        rsp_c_d     = ALU_C;
        rsp_v_d     = ALU_V;
        rsp_z_d     = (ALU_Y == '0);
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (RSP_READY) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      alu_osel_q  <= '0;
      alu_fn_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_y_q     <= '0;
      rsp_c_q     <= 1'b0;
      rsp_v_q     <= 1'b0;
      rsp_z_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      alu_osel_q  <= alu_osel_d;
      alu_fn_q    <= alu_fn_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_y_q     <= rsp_y_d;
      rsp_c_q     <= rsp_c_d;
      rsp_v_q     <= rsp_v_d;
      rsp_z_q     <= rsp_z_d;
    end
  end

  assign ALU_OSEL  = alu_osel_q;
  assign ALU_FN    = alu_fn_q;
  assign ALU_A     = alu_a_q;
  assign ALU_B     = alu_b_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_ID    = rsp_id_q;
  assign RSP_Y     = rsp_y_q;
  assign RSP_C     = rsp_c_q;
  assign RSP_V     = rsp_v_q;
  assign RSP_Z     = rsp_z_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: vector table plus scoreboard,
// with a behavioural ALU closing the loop.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic [NREQ-1:0]   REQ_VALID = '0;
  logic [NREQ-1:0]   REQ_READY;
  logic [2*NREQ-1:0] REQ_OSEL = '0;
  logic [4*NREQ-1:0] REQ_FN = '0;
  logic [8*NREQ-1:0] REQ_A = '0;
  logic [8*NREQ-1:0] REQ_B = '0;
  logic [1:0]        ALU_OSEL;
  logic [3:0]        ALU_FN;
  logic [7:0]        ALU_A;
  logic [7:0]        ALU_B;
  logic [7:0]        ALU_Y;
  logic              ALU_C;
  logic              ALU_V;
  logic              RSP_VALID;
  logic              RSP_READY = 1'b1;
  logic [IDW-1:0]    RSP_ID;
  logic [7:0]        RSP_Y;
  logic              RSP_C;
  logic              RSP_V;
  logic              RSP_Z;

  alu_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .REQ_VALID (REQ_VALID),
`ifdef ALU_ARB_LOCK_EN
    .REQ_LOCK  ('0),
`endif
    .REQ_READY (REQ_READY),
    .REQ_OSEL  (REQ_OSEL),
    .REQ_FN    (REQ_FN),
    .REQ_A     (REQ_A),
    .REQ_B     (REQ_B),
    .ALU_OSEL  (ALU_OSEL),
    .ALU_FN    (ALU_FN),
    .ALU_A     (ALU_A),
    .ALU_B     (ALU_B),
    .ALU_Y     (ALU_Y),
    .ALU_C     (ALU_C),
    .ALU_V     (ALU_V),
    .RSP_VALID (RSP_VALID),
    .RSP_READY (RSP_READY),
    .RSP_ID    (RSP_ID),
    .RSP_Y     (RSP_Y),
    .RSP_C     (RSP_C),
    .RSP_V     (RSP_V),
    .RSP_Z     (RSP_Z)
  );

  always #5 CLK = ~CLK;

  // Behavioural ALU: add/sub, shift, logic
  logic [7:0] bb;
  logic [8:0] sum9;
  logic [8:0] sh9;
  always_comb begin
    ALU_Y = '0;
    ALU_C = 1'b0;
    ALU_V = 1'b0;
    bb    = '0;
    sum9  = '0;
    sh9   = '0;
    if (ALU_OSEL == OSEL_ADD) begin
      bb    = ALU_FN[0] ? ~ALU_B : ALU_B;
      sum9  = {1'b0, ALU_A} + {1'b0, bb} + 9'(ALU_FN[0]);
      ALU_Y = sum9[7:0];
      ALU_C = sum9[8];
      ALU_V = (ALU_A[7] == bb[7]) && (sum9[7] != ALU_A[7]);
    end else if (ALU_OSEL == OSEL_SHIFT) begin
      if (!ALU_FN[0]) begin
        sh9   = {1'b0, ALU_A} << ALU_B[2:0];
        ALU_Y = sh9[7:0];
        ALU_C = sh9[8];
      end else begin
        if (ALU_FN[1])
          sh9 = $signed({ALU_A, 1'b0}) >>> ALU_B[2:0];
        else
          sh9 = {ALU_A, 1'b0} >> ALU_B[2:0];
        ALU_Y = sh9[8:1];
        ALU_C = sh9[0];
      end
    end else begin
      case (ALU_FN[1:0])
        2'd0:    ALU_Y = ALU_A & ALU_B;
        2'd1:    ALU_Y = ALU_A | ALU_B;
        2'd2:    ALU_Y = ALU_A ^ ALU_B;
        default: ALU_Y = ~ALU_A;
      endcase
    end
  end

  typedef struct packed {
    logic [1:0] id;
    logic [1:0] osel;
    logic [3:0] fn;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
    logic       c;
    logic       v;
    logic       z;
  } vec_t;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] y;
    logic       c;
    logic       v;
    logic       z;
  } exp_t;

  vec_t vecs [8];
  exp_t sb [$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", nm, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] id, input logic [7:0] y,
                              input logic c, input logic v,
                              input logic z);
    exp_t e;
    e.id = id;
    e.y  = y;
    e.c  = c;
    e.v  = v;
    e.z  = z;
    return e;
  endfunction

  // Scoreboard consumer: every handshaked response pops one entry
  always @(negedge CLK) begin
    if (RST_N && RSP_VALID && RSP_READY) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected got id=%0d y=%h required none",
                 RSP_ID, RSP_Y);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp", 32'({RSP_ID, RSP_Y, RSP_C, RSP_V, RSP_Z}),
            32'({mon_e.id, mon_e.y, mon_e.c, mon_e.v, mon_e.z}));
      end
    end
  end

  task automatic set_req(input int id, input logic [1:0] osel,
                         input logic [3:0] fn, input logic [7:0] a,
                         input logic [7:0] b);
    REQ_OSEL[2*id +: 2] = osel;
    REQ_FN[4*id +: 4]   = fn;
    REQ_A[8*id +: 8]    = a;
    REQ_B[8*id +: 8]    = b;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge CLK);
      #1;
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_grant();
    int n;
    n = 0;
    @(negedge CLK);
    while (REQ_READY == '0 && n < 20) begin
      @(negedge CLK);
      n++;
    end
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    RST_N     = 1'b0;
    REQ_VALID = '1;
    RSP_READY = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ready", 32'(REQ_READY), 32'd0);
    chk("rst_rsp", 32'({RSP_VALID, RSP_ID, RSP_Y, RSP_C, RSP_V, RSP_Z}),
        32'd0);
    chk("rst_alu", 32'({ALU_OSEL, ALU_FN, ALU_A, ALU_B}), 32'd0);
    @(posedge CLK);
    #1;
    REQ_VALID = '0;
    RST_N     = 1'b1;
  endtask

  task automatic do_req(input vec_t v);
    int id;
    id = int'(v.id);
    @(posedge CLK);
    #1;
    set_req(id, v.osel, v.fn, v.a, v.b);
    REQ_VALID[id] = 1'b1;
    sb.push_back(mk(v.id, v.y, v.c, v.v, v.z));
    wait_grant();
    chk("vec_grant", 32'(REQ_READY), 32'(1) << id);
    @(posedge CLK);
    #1;
    REQ_VALID = '0;
    @(negedge CLK);
    chk("vec_exec_valid", 32'(RSP_VALID), 32'd0);
    chk("vec_alu_bus", 32'({ALU_OSEL, ALU_FN, ALU_A, ALU_B}),
        32'({v.osel, v.fn, v.a, v.b}));
    @(negedge CLK);
    chk("vec_rsp_valid", 32'(RSP_VALID), 32'd1);
    wait_drain();
  endtask

  int order [5];
  int k;
  int cyc;
  int last;
  int n;

  initial begin
    #500000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{2'd0, OSEL_ADD,   4'h0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{2'd2, OSEL_ADD,   4'h0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{2'd1, OSEL_ADD,   4'h1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{2'd3, OSEL_SHIFT, 4'h0, 8'h81, 8'h01, 8'h02, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{2'd0, OSEL_SHIFT, 4'h3, 8'h80, 8'h02, 8'hE0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{2'd1, OSEL_LOGIC, 4'h0, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{2'd2, 2'b11,      4'h2, 8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{2'd3, OSEL_LOGIC, 4'h1, 8'h12, 8'h21, 8'h33, 1'b0, 1'b0, 1'b0};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      do_req(vecs[i]);
    end

    // Round-robin with all requesters continuously valid
    do_reset();
    order = '{0, 1, 2, 3, 0};
    @(posedge CLK);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      set_req(i, OSEL_ADD, 4'h0, 8'(8'h10 * i + 1), 8'h01);
    end
    for (int i = 0; i < 5; i++) begin
      sb.push_back(mk(2'(order[i]), 8'(8'h10 * order[i] + 2),
                      1'b0, 1'b0, 1'b0));
    end
    REQ_VALID = '1;
    k = 0;
    cyc = 0;
    last = 0;
    while (k < 5 && cyc < 60) begin
      @(negedge CLK);
      if (REQ_READY != '0) begin
        chk("rr_grant", 32'(REQ_READY), 32'(1) << order[k]);
        if (k > 0) chk("rr_space", 32'(cyc - last), 32'd3);
        last = cyc;
        k++;
      end
      cyc++;
    end
    chk("rr_count", 32'(k), 32'd5);
    @(posedge CLK);
    #1;
    REQ_VALID = '0;
    wait_drain();

    // Backpressure: response held, no accepts while RESP
    @(posedge CLK);
    #1;
    RSP_READY = 1'b0;
    set_req(1, OSEL_ADD, 4'h0, 8'h01, 8'h01);
    set_req(2, OSEL_ADD, 4'h0, 8'h21, 8'h01);
    REQ_VALID = 4'b0010;
    sb.push_back(mk(2'd1, 8'h02, 1'b0, 1'b0, 1'b0));
    wait_grant();
    chk("bp_grant", 32'(REQ_READY), 32'b0010);
    @(posedge CLK);
    #1;
    REQ_VALID = 4'b0100;
    n = 0;
    @(negedge CLK);
    while (!RSP_VALID && n < 10) begin
      @(negedge CLK);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", 32'({RSP_VALID, RSP_ID, RSP_Y, RSP_C, RSP_V, RSP_Z}),
          32'({1'b1, 2'd1, 8'h02, 1'b0, 1'b0, 1'b0}));
      chk("bp_ready", 32'(REQ_READY), 32'd0);
      @(negedge CLK);
    end
    @(posedge CLK);
    #1;
    RSP_READY = 1'b1;
    sb.push_back(mk(2'd2, 8'h22, 1'b0, 1'b0, 1'b0));
    @(negedge CLK);
    chk("bp_resp_ready", 32'(REQ_READY), 32'd0);
    @(negedge CLK);
    chk("bp_next_accept", 32'(REQ_READY), 32'b0100);
    @(posedge CLK);
    #1;
    REQ_VALID = '0;
    wait_drain();

    // Reset during EXEC drops the op and clears the pointer
    @(posedge CLK);
    #1;
    set_req(3, OSEL_ADD, 4'h0, 8'h31, 8'h01);
    set_req(0, OSEL_ADD, 4'h0, 8'h01, 8'h01);
    REQ_VALID = 4'b1000;
    wait_grant();
    chk("mid_grant", 32'(REQ_READY), 32'b1000);
    @(posedge CLK);
    #1;
    REQ_VALID = '0;
    RST_N     = 1'b0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("mid_no_rsp", 32'(RSP_VALID), 32'd0);
    end
    @(posedge CLK);
    #1;
    REQ_VALID = 4'b1001;
    sb.push_back(mk(2'd0, 8'h02, 1'b0, 1'b0, 1'b0));
    @(negedge CLK);
    chk("mid_ptr0", 32'(REQ_READY), 32'b0001);
    @(posedge CLK);
    #1;
    REQ_VALID = '0;
    wait_drain();
    repeat (3) @(posedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single 8-bit ALU (add / shift / logical datapath with output-select mux and C/V flags) between NREQ game-logic requesters, e.g. board-update, neighbour-count and score units. It arbitrates round-robin, registers the winner's operands and drives the ALU. It then captures Y/C/V plus a derived zero flag into a response register returned with the requester ID. One operation is in flight at a time; the ALU itself stays purely combinational.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of requester ID; must satisfy 2**IDW >= NREQ

Ports:
CLK  input  1  system clock, all logic on rising edge
RST_N  input  1  synchronous active-low reset
REQ_VALID  input  NREQ  per-requester request valid
REQ_READY  output  NREQ  per-requester accept strobe (one-hot or zero)
REQ_OSEL  input  2*NREQ  per-requester ALU output select, slice i = [2i+1:2i]
REQ_FN  input  4*NREQ  per-requester ALU sub-function (add/sub, shift dir/type, logic op)
REQ_A  input  8*NREQ  per-requester operand A
REQ_B  input  8*NREQ  per-requester operand B
ALU_OSEL  output  2  to ALU output mux select
ALU_FN  output  4  to ALU sub-units
ALU_A  output  8  ALU operand A
ALU_B  output  8  ALU operand B
ALU_Y  input  8  ALU result (combinational from ALU_* outputs)
ALU_C  input  1  ALU carry
ALU_V  input  1  ALU overflow
RSP_VALID  output  1  response valid
RSP_READY  input  1  response consumer ready
RSP_ID  output  IDW  index of requester owning the response
RSP_Y  output  8  captured result
RSP_C  output  1  captured carry
RSP_V  output  1  captured overflow
RSP_Z  output  1  captured zero flag, 1 when result == 8'h00

Behaviour:
- Reset (RST_N=0 at clock edge): state=IDLE, rr pointer=0, REQ_READY=0, ALU_OSEL/ALU_FN/ALU_A/ALU_B=0, RSP_VALID=0, RSP_ID/RSP_Y/RSP_C/RSP_V/RSP_Z=0. Any in-flight op is dropped with no response.
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any REQ_VALID, winner = first set bit scanning from rr pointer upward, wrapping mod NREQ. REQ_READY[winner]=1 combinationally in the same cycle. At the edge, latch winner's OSEL/FN/A/B into the ALU_* registers and its index into RSP_ID, set pointer=(winner+1) mod NREQ, go to EXEC. If no valid request, stay in IDLE; pointer is unchanged.
- REQ_READY is 0 in EXEC and RESP. A requester holds VALID and operands stable until it sees READY.
- EXEC: ALU_* registers drive the ALU for one full cycle. At the edge, capture ALU_Y/C/V into RSP_Y/C/V and RSP_Z=(ALU_Y==0), set RSP_VALID=1, go to RESP.
- RESP: hold all RSP_* stable while RSP_READY=0. On RSP_VALID & RSP_READY at the edge, RSP_VALID=0 and go to IDLE. RSP data keeps its last value.
- Latency: accept edge T, RSP_VALID high from T+2. Minimum spacing between accepts is 3 cycles.
- ALU_* outputs hold their last value outside EXEC; no glitching onto the ALU bus.
- Starvation bound: a continuously valid requester is accepted within NREQ arbitrations.
- Requester deasserting VALID before READY: no error detection; the request is simply not seen.
- RST_N low in any state overrides all transitions.

Optional Feature:
ALU_ARB_LOCK_EN.
- Defined: adds input REQ_LOCK[NREQ-1:0]. If REQ_LOCK[winner] is 1 when accepted, the pointer is set to winner instead of winner+1. The winner then holds top priority on the next arbitration, so multi-byte sequences (e.g. 16-bit score add) are not interleaved. Lock releases when the locked requester is accepted with REQ_LOCK=0, or when it has no VALID in an IDLE cycle while others do.
- Undefined: port absent; pointer always advances to winner+1.

Decomposition:
- Package alu_arb_pkg: OSEL encodings (OSEL_ADD=2'b00, OSEL_SHIFT=2'b01, OSEL_LOGIC=2'b1x), FN field width, state enum {IDLE, EXEC, RESP}, default NREQ/IDW.
- One sub-module, rr_pick: combinational round-robin picker. Inputs are the request vector and pointer; outputs are a one-hot grant and the index.

Test Plan:
- Reset: RST_N=0 for 2 cycles with all REQ_VALID=1 -> REQ_READY=0, RSP_VALID=0, all RSP_* and ALU_* = 0.
- Single add: req0 OSEL=00, A=8'h7F, B=8'h01, RSP_READY=1 -> READY[0] at T, RSP_VALID at T+2, RSP_ID=0, Y=8'h80, C=0, V=1, Z=0.
- Zero/carry: req2 OSEL=00, A=8'hFF, B=8'h01 -> Y=8'h00, C=1, Z=1, RSP_ID=2.
- Round-robin: all 4 VALID continuously, RSP_READY=1 -> grant order 0,1,2,3,0, one accept every 3 cycles.
- Backpressure: RSP_READY=0 for 5 cycles after RSP_VALID -> RSP_* stable, no REQ_READY. RSP_READY=1 -> next accept occurs in the following IDLE cycle.
- Reset mid-op: RST_N=0 during EXEC -> no response issued, pointer=0; after release, req0 wins first.
